// File: rtl/rv32_pkg.sv
// Shared types for the RV32 hart scheduler: per-hart state encoding and defaults.
package rv32_pkg;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_RUN  = 2'd1,
        HS_WAIT = 2'd2,
        HS_TRAP = 2'd3
    } rv32_hart_state_t;

    localparam int RV32_NUM_HARTS = 8;
    localparam int RV32_CNT_W     = 32;

endpackage

// File: rtl/rv32_hart_fsm.sv
// Per-hart IDLE/RUN/WAIT/TRAP state machine; events arrive already decoded for this hart.
module rv32_hart_fsm
    import rv32_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_trap,
    input  logic             i_stall_set,
    input  logic             i_stall_clr,
    input  logic             i_trap_ack,
    output rv32_hart_state_t o_state
);

    rv32_hart_state_t r_state;
    rv32_hart_state_t w_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= HS_IDLE;
        else       r_state <= w_next;
    end

    // Highest-priority event that applies in the current state wins.
    always_comb begin
        w_next = r_state;
        if (!i_en) begin
            w_next = HS_IDLE;
        end else begin
            case (r_state)
                HS_IDLE: w_next = HS_RUN;
                HS_RUN: begin
                    if (i_trap)           w_next = HS_TRAP;
                    else if (i_stall_set) w_next = HS_WAIT;
                end
                HS_WAIT: begin
                    if (i_trap)           w_next = HS_TRAP;
                    else if (i_stall_clr) w_next = HS_RUN;
                end
                HS_TRAP: begin
                    if (i_trap_ack)       w_next = HS_RUN;
                end
                default: w_next = HS_IDLE;
            endcase
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/rv32_rr_arbiter.sv
// Combinational round-robin search: first requesting index at or above i_ptr, wrapping.
module rv32_rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_gnt_valid,
    output logic [IDX_W-1:0] o_gnt_idx
);

    logic [IDX_W:0] w_sum;

    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        w_sum       = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N))
                w_sum = w_sum - (IDX_W+1)'(N);
            if (!o_gnt_valid && i_req[w_sum[IDX_W-1:0]]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rv32_hart_scheduler.sv
// Barrel-style hart scheduler: per-hart FSMs feed a round-robin issue offer.
// Optional per-hart issue counters built when RV32_HART_PERF_EN is defined.
module rv32_hart_scheduler
    import rv32_pkg::*;
#(
    parameter int NUM_HARTS = RV32_NUM_HARTS,
    parameter int HART_ID_W = $clog2(NUM_HARTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_HARTS-1:0]   hart_en,
    input  logic                   issue_ready,
    output logic                   issue_valid,
    output logic [HART_ID_W-1:0]   issue_hart,
    input  logic                   stall_set,
    input  logic [HART_ID_W-1:0]   stall_set_hart,
    input  logic                   stall_clr,
    input  logic [HART_ID_W-1:0]   stall_clr_hart,
    input  logic                   trap,
    input  logic [HART_ID_W-1:0]   trap_hart,
    input  logic                   trap_ack,
    input  logic [HART_ID_W-1:0]   trap_ack_hart,
    output logic [2*NUM_HARTS-1:0] hart_state,
    output logic                   all_idle
`ifdef RV32_HART_PERF_EN
    ,
    input  logic                            perf_clr,
    output logic [RV32_CNT_W*NUM_HARTS-1:0] issue_cnt
`endif
);

    rv32_hart_state_t     w_state [NUM_HARTS];
    logic [NUM_HARTS-1:0] w_run;
    logic [NUM_HARTS-1:0] w_busy;
    logic [HART_ID_W-1:0] r_rr_ptr;
    logic                 w_xfer;

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
        rv32_hart_fsm u_fsm (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_en        (hart_en[g]),
            .i_trap      (trap      && (trap_hart      == HART_ID_W'(g))),
            .i_stall_set (stall_set && (stall_set_hart == HART_ID_W'(g))),
            .i_stall_clr (stall_clr && (stall_clr_hart == HART_ID_W'(g))),
            .i_trap_ack  (trap_ack  && (trap_ack_hart  == HART_ID_W'(g))),
            .o_state     (w_state[g])
        );
        assign hart_state[2*g +: 2] = w_state[g];
        assign w_run[g]  = (w_state[g] == HS_RUN);
        assign w_busy[g] = (w_state[g] == HS_RUN) || (w_state[g] == HS_WAIT);
    end

    rv32_rr_arbiter #(
        .N     (NUM_HARTS),
        .IDX_W (HART_ID_W)
    ) u_arb (
        .i_req       (w_run),
        .i_ptr       (r_rr_ptr),
        .o_gnt_valid (issue_valid),
        .o_gnt_idx   (issue_hart)
    );

    assign w_xfer   = issue_valid && issue_ready;
    assign all_idle = ~|w_busy;

    // Pointer only moves on a transfer, which keeps the offer stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            if (issue_hart == HART_ID_W'(NUM_HARTS-1)) r_rr_ptr <= '0;
            else                                        r_rr_ptr <= issue_hart + 1'b1;
        end
    end

`ifdef RV32_HART_PERF_EN
    logic [NUM_HARTS-1:0][RV32_CNT_W-1:0] r_issue_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_issue_cnt <= '0;
        else if (perf_clr)
            r_issue_cnt <= '0;
        else if (w_xfer)
            r_issue_cnt[issue_hart] <= r_issue_cnt[issue_hart] + 1'b1;
    end

    assign issue_cnt = r_issue_cnt;
`endif

endmodule

// File: tb/tb_rv32_hart_scheduler.sv
// Directed vector bench for rv32_hart_scheduler (8 harts); perf counters checked when RV32_HART_PERF_EN is set.
module tb_rv32_hart_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  hart_en;
    logic        issue_ready;
    logic        issue_valid;
    logic [2:0]  issue_hart;
    logic        stall_set, stall_clr, trap, trap_ack;
    logic [2:0]  stall_set_hart, stall_clr_hart, trap_hart, trap_ack_hart;
    logic [15:0] hart_state;
    logic        all_idle;
`ifdef RV32_HART_PERF_EN
    logic         perf_clr;
    logic [255:0] issue_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    rv32_hart_scheduler #(.NUM_HARTS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .hart_en        (hart_en),
        .issue_ready    (issue_ready),
        .issue_valid    (issue_valid),
        .issue_hart     (issue_hart),
        .stall_set      (stall_set),
        .stall_set_hart (stall_set_hart),
        .stall_clr      (stall_clr),
        .stall_clr_hart (stall_clr_hart),
        .trap           (trap),
        .trap_hart      (trap_hart),
        .trap_ack       (trap_ack),
        .trap_ack_hart  (trap_ack_hart),
        .hart_state     (hart_state),
        .all_idle       (all_idle)
`ifdef RV32_HART_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .issue_cnt      (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Events encoded as {valid, hart[2:0]}.
    typedef struct {
        logic [7:0]  en;
        logic        rdy;
        logic [3:0]  ss, sc, tr, ta;
        logic        ev;
        logic [2:0]  eh;
        logic [15:0] est;
        logic        ei;
    } vec_t;

    vec_t vt [29];

    function automatic vec_t mk(input logic [7:0] en, input logic rdy,
                                input logic [3:0] ss, input logic [3:0] sc,
                                input logic [3:0] tr, input logic [3:0] ta,
                                input logic ev, input logic [2:0] eh,
                                input logic [15:0] est, input logic ei);
        vec_t v;
        v.en = en; v.rdy = rdy; v.ss = ss; v.sc = sc; v.tr = tr; v.ta = ta;
        v.ev = ev; v.eh = eh; v.est = est; v.ei = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hart_en        = v.en;
        issue_ready    = v.rdy;
        stall_set      = v.ss[3]; stall_set_hart = v.ss[2:0];
        stall_clr      = v.sc[3]; stall_clr_hart = v.sc[2:0];
        trap           = v.tr[3]; trap_hart      = v.tr[2:0];
        trap_ack       = v.ta[3]; trap_ack_hart  = v.ta[2:0];
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [2:0] eh,
                              input logic [15:0] est, input logic ei);
        check({tag, " valid"}, 32'(issue_valid), 32'(ev));
        check({tag, " hart"},  32'(issue_hart),  32'(eh));
        check({tag, " state"}, 32'(hart_state),  32'(est));
        check({tag, " idle"},  32'(all_idle),    32'(ei));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle_v;
        //          en    rdy ss    sc    tr    ta    ev eh  state    idle
        vt[0]  = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 16'h5555, 0);
        vt[1]  = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 16'h5555, 0);
        vt[2]  = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2, 16'h5555, 0);
        vt[3]  = mk(8'hFF,1, 4'hB, 4'h0, 4'h0, 4'h0, 1, 4, 16'h5595, 0);
        vt[4]  = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 5, 16'h5595, 0);
        vt[5]  = mk(8'hFF,1, 4'h0, 4'hB, 4'h0, 4'h0, 1, 6, 16'h5555, 0);
        vt[6]  = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 7, 16'h5555, 0);
        vt[7]  = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 16'h5555, 0);
        vt[8]  = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 16'h5555, 0);
        vt[9]  = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2, 16'h5555, 0);
        vt[10] = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 3, 16'h5555, 0);
        vt[11] = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4, 16'h5555, 0);
        vt[12] = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 5, 16'h5555, 0);
        vt[13] = mk(8'hFF,0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 5, 16'h5555, 0);
        vt[14] = mk(8'hFF,0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 5, 16'h5555, 0);
        vt[15] = mk(8'hFF,0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 5, 16'h5555, 0);
        vt[16] = mk(8'hFF,0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 5, 16'h5555, 0);
        vt[17] = mk(8'hFF,1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 6, 16'h5555, 0);
        vt[18] = mk(8'hFF,0, 4'hA, 4'h0, 4'hA, 4'h0, 1, 6, 16'h5575, 0);
        vt[19] = mk(8'hFF,0, 4'h0, 4'hA, 4'h0, 4'h0, 1, 6, 16'h5575, 0);
        vt[20] = mk(8'hFF,0, 4'h0, 4'h0, 4'h0, 4'hA, 1, 6, 16'h5555, 0);
        vt[21] = mk(8'hFF,0, 4'h0, 4'h9, 4'h0, 4'h0, 1, 6, 16'h5555, 0);
        vt[22] = mk(8'hFF,0, 4'h0, 4'h0, 4'h0, 4'hC, 1, 6, 16'h5555, 0);
        vt[23] = mk(8'hFF,1, 4'hE, 4'h0, 4'hF, 4'h0, 1, 0, 16'hE555, 0);
        vt[24] = mk(8'h7F,0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 16'h2555, 0);
        vt[25] = mk(8'hFF,0, 4'h0, 4'hE, 4'hE, 4'h0, 1, 7, 16'h7555, 0);
        vt[26] = mk(8'h01,0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 16'h0001, 0);
        vt[27] = mk(8'h01,0, 4'h8, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0002, 0);
        vt[28] = mk(8'h00,0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 1);
        idle_v = mk(8'h00,0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 1);

        rst = 1'b1;
        drive(idle_v);
`ifdef RV32_HART_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 3'd0, 16'h0000, 1'b1);
`ifdef RV32_HART_PERF_EN
        check("reset cnt", 32'(issue_cnt != '0), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            drive(vt[i]);
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), vt[i].ev, vt[i].eh, vt[i].est, vt[i].ei);
        end

        // Mid-stream reset with harts in WAIT and TRAP; rr pointer sits at 7 beforehand.
        drive(mk(8'hFF,0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0, 0));
        @(posedge clk); #1;
        check_outs("rearm", 1'b1, 3'd7, 16'h5555, 1'b0);
        drive(mk(8'hFF,0, 4'h9, 4'h0, 4'hC, 4'h0, 0, 0, 16'h0, 0));
        @(posedge clk); #1;
        check_outs("wait_trap", 1'b1, 3'd7, 16'h5759, 1'b0);
`ifdef RV32_HART_PERF_EN
        check("cnt hart0", issue_cnt[31:0], 32'd2);
        check("cnt hart6", issue_cnt[223:192], 32'd2);
`endif
        drive(mk(8'hFF,0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0, 0));
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 3'd0, 16'h0000, 1'b1);
`ifdef RV32_HART_PERF_EN
        check("rst cnt", 32'(issue_cnt != '0), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_outs("post_rst", 1'b1, 3'd0, 16'h5555, 1'b0);
        issue_ready = 1'b1;
        @(posedge clk); #1;
        check_outs("post_rst_xfer", 1'b1, 3'd1, 16'h5555, 1'b0);
`ifdef RV32_HART_PERF_EN
        check("cnt after xfer", issue_cnt[31:0], 32'd1);
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        check("perf_clr", 32'(issue_cnt != '0), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
